rdyval_pack: RTL and testbench
==============================

# rdyval_pack

Ready–valid width up-converter: collects `RATIO` consecutive narrow beats into one wide word and presents it downstream with a registered valid. It sits directly upstream of a ready–valid pipeline stage and feeds it full-width words from a narrow producer such as a byte stream. The block sustains one input beat per cycle with no bubbles, including when a word completes while the previous word is being drained.

## Interface
- `DWIDTH`, 8: input beat width in bits, ≥1.
- `RATIO`, 4: beats per output word, ≥2; output width is `DWIDTH*RATIO`.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `vld`  in  1  upstream beat valid.
- `rdy`  out  1  upstream ready; combinational.
- `i_dat`  in  DWIDTH  upstream beat data.
- `i_last`  in  1  end-of-packet marker; present only with `RDYVAL_PACK_LAST_EN`.
- `vld_nxt`  out  1  downstream word valid; registered.
- `rdy_nxt`  in  1  downstream ready.
- `o_dat`  out  DWIDTH*RATIO  packed word.
- `o_keep`  out  RATIO  lane-valid mask; present only with `RDYVAL_PACK_LAST_EN`.

## Operation
- An input transfer (`acc_x`) occurs when `vld & rdy`.
- An output transfer (`out_x`) occurs when `vld_nxt & rdy_nxt`.
- **Beat counter `idx`**, range 0..RATIO-1, `clog2(RATIO)` bits:
  - increments on each `acc_x`;
  - returns to 0 on a completing beat; never wraps past RATIO-1.
- **Lane placement:** beat k is written to `o_dat[k*DWIDTH +: DWIDTH]`, little-endian. The first beat of a word lands in lane 0.
- **Internal registers:**
  - accumulator holds lanes 0..RATIO-2;
  - output register holds the completed word and drives `o_dat`.
- **Completing beat:** an `acc_x` with `idx==RATIO-1`, or with `i_last=1` when the macro is compiled in. On a completing beat, in a single edge:
  - output register ← {`i_dat`, accumulator lanes};
  - `vld_nxt` ← 1;
  - `idx` ← 0.
- **`vld_nxt` update:** cleared on `out_x` unless a completing beat occurs in the same cycle; in that case it stays 1 and the new word is loaded.
- **`rdy` without the macro:** `rdy = rst_n & ((idx != RATIO-1) | ~vld_nxt | rdy_nxt)`. Non-completing beats are accepted while the output is stalled.
- **`rdy` with the macro:** `rdy = rst_n & (~vld_nxt | rdy_nxt)`. `rdy` never depends on `i_last` or `i_dat`.
- **Output stability:** `o_dat`, `o_keep` and `vld_nxt` are held stable while `vld_nxt & ~rdy_nxt`.
- **Upstream protocol:** a beat may be presented with `vld` before `rdy` is high. `vld` is not withdrawn until the beat is accepted.
- **Reset:**
  - `vld_nxt`=0 and `idx`=0 after the first edge with `rst_n` low;
  - `rdy`=0 while `rst_n` is low;
  - a partially assembled word is discarded;
  - data registers (accumulator, `o_dat`, `o_keep`) have no reset; their value is don't-care until the first load.
- **Reset while `vld_nxt`=1:** the held word is dropped and never transferred.

## Timing
- **Latency:** the completing beat is accepted at edge N; `vld_nxt`=1 and `o_dat` are valid after edge N.
- **Throughput:** one word per RATIO cycles with continuous `vld` and `rdy_nxt`=1; no bubbles.
- **Back-to-back overlap:** `out_x` and a completing `acc_x` in the same cycle hand over with no idle cycle on `vld_nxt`.
- **Downstream stall:** the upstream stalls only at the completing beat (`idx==RATIO-1`, no macro), or at any beat while the output is full (macro).

## Configuration
- Macro: `RDYVAL_PACK_LAST_EN`.
- **Defined:**
  - `i_last` and `o_keep` ports exist;
  - a beat with `i_last=1` completes the word early;
  - `o_keep[k]`=1 for each lane written in that word;
  - unwritten lanes of `o_dat` are driven 0;
  - `rdy` follows the conservative equation in Operation.
- **Undefined:**
  - no `i_last`/`o_keep` ports;
  - every word carries exactly RATIO beats;
  - `rdy` follows the non-macro equation.

## Test plan
- **Basic packing** (DWIDTH=8, RATIO=4, `rdy_nxt`=1): send 11,22,33,44 on consecutive cycles. Required: `o_dat`=32'h44332211 and `vld_nxt`=1 for one cycle, after the 4th beat's edge.
- **Continuous stream:** 16 beats 00..0F with no gaps, `rdy_nxt`=1. Required:
  - words 03020100, 07060504, 0B0A0908, 0F0E0D0C;
  - `rdy` constantly 1;
  - `vld_nxt` high every 4th cycle.
- **Downstream stall:** hold `rdy_nxt`=0 after the first word. Required:
  - beats 4–6 are accepted;
  - `rdy`=0 at `idx`=3;
  - `o_dat` stays 44332211;
  - raising `rdy_nxt` loads the next word with no idle `vld_nxt` cycle.
- **Reset mid-word:** `rst_n` low after 2 beats. Required:
  - `vld_nxt`=0 and `rdy`=0 during reset;
  - the next 4 beats AA,BB,CC,DD yield DDCCBBAA.
- **Early last** (macro defined): send 11,22 with `i_last` on 22. Required: `o_dat`=32'h00002211, `o_keep`=4'b0011.
- **Last on final lane** (macro defined): `i_last` on the 4th beat. Required: `o_keep`=4'b1111, and the next word starts at lane 0.

Source files
------------

// File: rtl/rdyval_pack.sv
// rdyval_pack: ready/valid width up-converter.
// Collects RATIO narrow beats of DWIDTH bits into one DWIDTH*RATIO word.
// Beat k of a word goes to lane k (little-endian). The word is presented
// downstream from a registered output stage with a registered valid.
// Optional feature macro: RDYVAL_PACK_LAST_EN adds i_last (early word
// completion) and o_keep (lane-valid mask); unwritten lanes read as zero.
`timescale 1ns/1ps

module rdyval_pack #(
    parameter int DWIDTH = 8,
    parameter int RATIO  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vld,
    output logic                     rdy,
    input  logic [DWIDTH-1:0]        i_dat,
`ifdef RDYVAL_PACK_LAST_EN
    input  logic                     i_last,
    output logic [RATIO-1:0]         o_keep,
`endif
    output logic                     vld_nxt,
    input  logic                     rdy_nxt,
    output logic [DWIDTH*RATIO-1:0]  o_dat
);

    localparam int             IW       = $clog2(RATIO);
    localparam logic [IW-1:0]  IDX_LAST = IW'(RATIO - 1);

    logic [IW-1:0]               idx;
    logic [DWIDTH*(RATIO-1)-1:0] acc;
    logic [DWIDTH*RATIO-1:0]     word;
    logic                        acc_x;
    logic                        out_x;
    logic                        done;

    assign acc_x = vld & rdy;
    assign out_x = vld_nxt & rdy_nxt;

`ifdef RDYVAL_PACK_LAST_EN
    logic [RATIO-1:0] keep_nxt;

    // Any beat may complete the word, so the upstream waits whenever the output is full.
    assign done = acc_x & ((idx == IDX_LAST) | i_last);
    assign rdy  = rst_n & (~vld_nxt | rdy_nxt);

    // Lanes up to and including the current beat are valid in the completed word.
    always_comb begin
        keep_nxt = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (IW'(k) <= idx) begin
                keep_nxt[k] = 1'b1;
            end
        end
    end
`else
    // Only the final lane needs a free output register; earlier beats keep flowing.
    assign done = acc_x & (idx == IDX_LAST);
    assign rdy  = rst_n & ((idx != IDX_LAST) | ~vld_nxt | rdy_nxt);
`endif

    // Completed word: accumulated lanes below idx, current beat at idx, zeros above.
    always_comb begin
        word = '0;
        for (int k = 0; k < RATIO - 1; k++) begin
            if (IW'(k) < idx) begin
                word[k*DWIDTH +: DWIDTH] = acc[k*DWIDTH +: DWIDTH];
            end
        end
        for (int k = 0; k < RATIO; k++) begin
            if (IW'(k) == idx) begin
                word[k*DWIDTH +: DWIDTH] = i_dat;
            end
        end
    end

    // Beat counter and output valid; a completing beat overrides a same-cycle drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx     <= '0;
            vld_nxt <= 1'b0;
        end else if (done) begin
            idx     <= '0;
            vld_nxt <= 1'b1;
        end else begin
            if (acc_x) begin
                idx <= idx + 1'b1;
            end
            if (out_x) begin
                vld_nxt <= 1'b0;
            end
        end
    end

    // Data path: accumulate partial lanes, load the output register on completion.
    always_ff @(posedge clk) begin
        if (acc_x && !done) begin
            for (int k = 0; k < RATIO - 1; k++) begin
                if (idx == IW'(k)) begin
                    acc[k*DWIDTH +: DWIDTH] <= i_dat;
                end
            end
        end
        if (done) begin
            o_dat <= word;
`ifdef RDYVAL_PACK_LAST_EN
            o_keep <= keep_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_rdyval_pack.sv
// Directed self-checking bench for rdyval_pack (DWIDTH=8, RATIO=4).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Early-last cases are exercised when RDYVAL_PACK_LAST_EN
// is defined; the downstream-stall case is run for the default build.
`timescale 1ns/1ps

module tb_rdyval_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld;
    logic        rdy;
    logic [7:0]  i_dat;
    logic        i_last;
    logic        vld_nxt;
    logic        rdy_nxt;
    logic [31:0] o_dat;
`ifdef RDYVAL_PACK_LAST_EN
    logic [3:0]  o_keep;
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] words [4];

    rdyval_pack #(.DWIDTH(8), .RATIO(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld     (vld),
        .rdy     (rdy),
        .i_dat   (i_dat),
`ifdef RDYVAL_PACK_LAST_EN
        .i_last  (i_last),
        .o_keep  (o_keep),
`endif
        .vld_nxt (vld_nxt),
        .rdy_nxt (rdy_nxt),
        .o_dat   (o_dat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, confirm it will be taken, and move past the accepting edge.
    task automatic send(input logic [7:0] d, input logic last);
        vld    = 1'b1;
        i_dat  = d;
        i_last = last;
        @(negedge clk);
        chk("send_rdy", {63'd0, rdy}, 64'd1);
        tick();
        vld    = 1'b0;
        i_last = 1'b0;
    endtask

    initial begin
        words[0] = 32'h03020100;
        words[1] = 32'h07060504;
        words[2] = 32'h0B0A0908;
        words[3] = 32'h0F0E0D0C;

        rst_n   = 1'b0;
        vld     = 1'b0;
        i_dat   = 8'h00;
        i_last  = 1'b0;
        rdy_nxt = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("reset_vld_nxt", {63'd0, vld_nxt}, 64'd0);
        chk("reset_rdy", {63'd0, rdy}, 64'd0);
        tick();
        rst_n = 1'b1;

        // Basic packing
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        @(negedge clk);
        chk("basic_vld_early", {63'd0, vld_nxt}, 64'd0);
        tick();
        send(8'h44, 1'b0);
        @(negedge clk);
        chk("basic_vld", {63'd0, vld_nxt}, 64'd1);
        chk("basic_dat", {32'd0, o_dat}, 64'h44332211);
        tick();
        @(negedge clk);
        chk("basic_vld_drop", {63'd0, vld_nxt}, 64'd0);
        tick();

        // Continuous stream, no gaps
        for (int i = 0; i < 16; i++) begin
            vld   = 1'b1;
            i_dat = 8'(i);
            @(negedge clk);
            chk("stream_rdy", {63'd0, rdy}, 64'd1);
            if (i >= 4 && i % 4 == 0) begin
                chk("stream_vld", {63'd0, vld_nxt}, 64'd1);
                chk("stream_word", {32'd0, o_dat}, {32'd0, words[i/4-1]});
            end else begin
                chk("stream_vld_low", {63'd0, vld_nxt}, 64'd0);
            end
            tick();
        end
        vld = 1'b0;
        @(negedge clk);
        chk("stream_last_vld", {63'd0, vld_nxt}, 64'd1);
        chk("stream_last_word", {32'd0, o_dat}, 64'h0F0E0D0C);
        tick();

`ifndef RDYVAL_PACK_LAST_EN
        // Downstream stall
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        rdy_nxt = 1'b0;
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        vld   = 1'b1;
        i_dat = 8'h88;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_rdy", {63'd0, rdy}, 64'd0);
            chk("stall_vld", {63'd0, vld_nxt}, 64'd1);
            chk("stall_dat", {32'd0, o_dat}, 64'h44332211);
            tick();
        end
        rdy_nxt = 1'b1;
        @(negedge clk);
        chk("release_rdy", {63'd0, rdy}, 64'd1);
        tick();
        vld = 1'b0;
        @(negedge clk);
        chk("handover_vld", {63'd0, vld_nxt}, 64'd1);
        chk("handover_dat", {32'd0, o_dat}, 64'h88776655);
        tick();
        @(negedge clk);
        chk("handover_drain", {63'd0, vld_nxt}, 64'd0);
        tick();
`endif

        // Reset mid-word; a beat held during reset must not be taken
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        rst_n = 1'b0;
        vld   = 1'b1;
        i_dat = 8'hEE;
        tick();
        @(negedge clk);
        chk("midrst_vld_nxt", {63'd0, vld_nxt}, 64'd0);
        chk("midrst_rdy", {63'd0, rdy}, 64'd0);
        tick();
        vld   = 1'b0;
        rst_n = 1'b1;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        send(8'hDD, 1'b0);
        rdy_nxt = 1'b0;
        @(negedge clk);
        chk("midrst_word_vld", {63'd0, vld_nxt}, 64'd1);
        chk("midrst_word", {32'd0, o_dat}, 64'hDDCCBBAA);

        // Reset while a word is held drops it
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("heldrst_vld_nxt", {63'd0, vld_nxt}, 64'd0);
        tick();
        rst_n   = 1'b1;
        rdy_nxt = 1'b1;

`ifdef RDYVAL_PACK_LAST_EN
        // Early last
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        @(negedge clk);
        chk("early_vld", {63'd0, vld_nxt}, 64'd1);
        chk("early_dat", {32'd0, o_dat}, 64'h00002211);
        chk("early_keep", {60'd0, o_keep}, 64'h3);
        tick();

        // Last on final lane, then next word restarts at lane 0
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b1);
        @(negedge clk);
        chk("final_dat", {32'd0, o_dat}, 64'h66554433);
        chk("final_keep", {60'd0, o_keep}, 64'hF);
        tick();
        send(8'h77, 1'b1);
        @(negedge clk);
        chk("restart_dat", {32'd0, o_dat}, 64'h00000077);
        chk("restart_keep", {60'd0, o_keep}, 64'h1);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
